// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file write scheduler.
// Holds register-file geometry and the write-source encoding.
package cpu_pkg;

    localparam int NUM_REGS     = 32;
    localparam int ADDR_W       = 5;
    localparam int STARVE_LIMIT = 8;

    // Write-port source; also the encoding of the round-robin pointer.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LOAD,
        SRC_DIV
    } wb_src_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Scoreboard: pending vector, hazard stall and sticky error flag.
// Ports: issue_* in, clr_en/clr_addr (long grant), alu_* in,
//        stall / pending / sb_err out.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int ADDR_W   = cpu_pkg::ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_long,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic [ADDR_W-1:0]   issue_rs2,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    input  logic                alu_wren,
    input  logic [ADDR_W-1:0]   alu_addr,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic                sb_err
);

    logic                set_en;
    logic                err_now;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Registered pending only; a same-cycle clear releases next cycle.
    assign stall = issue_valid &
                   (pending[issue_rs1] |
                    pending[issue_rs2] |
                    pending[issue_rd]);

    assign set_en = issue_valid & issue_long & ~stall &
                    (issue_rd != '0);

    assign set_mask = set_en ? (NUM_REGS'(1) << issue_rd) : '0;
    assign clr_mask = clr_en ? (NUM_REGS'(1) << clr_addr) : '0;

    assign err_now = (clr_en & ~pending[clr_addr]) |
                     (alu_wren & pending[alu_addr]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            // Bit 0 is forced clear: r0 never has a pending write.
            pending <= ((pending & ~clr_mask) | set_mask) &
                       ~NUM_REGS'(1);
            sb_err  <= sb_err | err_now;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Shares the single register-file write port between ALU, load and divide.
// Ports: issue_* / stall, alu_* / alu_hold, ld_* / div_* handshakes,
//        rf_* write port, pending scoreboard, sticky sb_err.
module regfile_wb_sched
    import cpu_pkg::*;
#(
    parameter int NUM_REGS     = cpu_pkg::NUM_REGS,
    parameter int ADDR_W       = cpu_pkg::ADDR_W,
    parameter int STARVE_LIMIT = cpu_pkg::STARVE_LIMIT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_long,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic [ADDR_W-1:0]   issue_rs2,
    output logic                stall,
    input  logic                alu_wren,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [31:0]         alu_data,
    output logic                alu_hold,
    input  logic                ld_valid,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [31:0]         ld_data,
    output logic                ld_ready,
    input  logic                div_valid,
    input  logic [ADDR_W-1:0]   div_addr,
    input  logic [31:0]         div_data,
    output logic                div_ready,
    output logic                rf_wren,
    output logic [ADDR_W-1:0]   rf_wraddress,
    output logic [31:0]         rf_data,
    output logic [NUM_REGS-1:0] pending,
    output logic                sb_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_src_t           grant;
    wb_src_t           rr_ptr;
    logic [SW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] g_addr;
    logic [31:0]       g_data;
    logic              long_req;
    logic              long_grant;
    logic              both_req;
    logic              refused;

    assign long_req   = ld_valid | div_valid;
    assign both_req   = ld_valid & div_valid;
    assign long_grant = (grant == SRC_LOAD) | (grant == SRC_DIV);
    assign refused    = long_req & ~long_grant;

    // Overlapping requests, so a priority chain rather than a parallel case.
    always_comb begin
        grant = SRC_NONE;
        if (alu_wren)
            grant = SRC_ALU;
        else if (both_req)
            grant = rr_ptr;
        else if (ld_valid)
            grant = SRC_LOAD;
        else if (div_valid)
            grant = SRC_DIV;
    end

    always_comb begin
        g_addr = '0;
        g_data = '0;
        unique case (grant)
            SRC_ALU: begin
                g_addr = alu_addr;
                g_data = alu_data;
            end
            SRC_LOAD: begin
                g_addr = ld_addr;
                g_data = ld_data;
            end
            SRC_DIV: begin
                g_addr = div_addr;
                g_data = div_data;
            end
            default: ;
        endcase
    end

    // A write to r0 is acknowledged but never reaches the array.
    assign rf_wren      = (grant != SRC_NONE) & (g_addr != '0);
    assign rf_wraddress = g_addr;
    assign rf_data      = g_data;
    assign ld_ready     = (grant == SRC_LOAD);
    assign div_ready    = (grant == SRC_DIV);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr     <= SRC_LOAD;
            starve_cnt <= '0;
            alu_hold   <= 1'b0;
        end else begin
            // Pointer only moves when it actually arbitrated.
            if (both_req & long_grant)
                rr_ptr <= (rr_ptr == SRC_LOAD) ? SRC_DIV : SRC_LOAD;
            if (!refused)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
            alu_hold <= refused &
                        (starve_cnt == SW'(STARVE_LIMIT - 1));
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .clr_en      (long_grant),
        .clr_addr    (g_addr),
        .alu_wren    (alu_wren),
        .alu_addr    (alu_addr),
        .stall       (stall),
        .pending     (pending),
        .sb_err      (sb_err)
    );

endmodule
